// File: rtl/cam_sccb_init.sv
// Camera bring-up sequencer: free-running XCLK, PWDN/RESET power-up
// sequence, then an SCCB write of every {reg, value} entry of an external
// synchronous ROM table until a 16'hFFFF terminator or the last address.
//
// Start handshake: start is a single-cycle request. It is accepted only
// while the sequencer is idle (IDLE or FIN). busy rises the cycle after
// acceptance and falls together with the rise of done. A start seen while
// busy is dropped.
module cam_sccb_init #(
    parameter int         CLK_DIV    = 12,
    parameter int         XCLK_DIV   = 2,
    parameter logic [7:0] SLAVE_ADDR = 8'h42,
    parameter int         RESET_HOLD = 48000,
    parameter int         BOOT_WAIT  = 48000,
    parameter int         ROM_AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              nack_err,
    output logic              cam_xclk,
    output logic              cam_pwdn,
    output logic              cam_reset,
    output logic              scl,
    output logic              sda_oe,
    input  logic              sda_in,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PWRUP = 4'd1,
        S_BOOT  = 4'd2,
        S_FETCH = 4'd3,
        S_START = 4'd4,
        S_BYTE  = 4'd5,
        S_ACK   = 4'd6,
        S_STOP  = 4'd7,
        S_GAP   = 4'd8,
        S_FIN   = 4'd9
    } state_t;

    // One shared cycle counter covers the longest wait in any state.
    localparam int CNT_MAX = (RESET_HOLD > BOOT_WAIT)
                           ? ((RESET_HOLD > 4*CLK_DIV) ? RESET_HOLD : 4*CLK_DIV)
                           : ((BOOT_WAIT  > 4*CLK_DIV) ? BOOT_WAIT  : 4*CLK_DIV);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int XW      = $clog2(XCLK_DIV + 1);

    localparam logic [CNT_W-1:0] T_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_RST_END  = CNT_W'(RESET_HOLD - 1);
    // The two FETCH cycles of entry 0 are folded into the boot wait, so the
    // first START lands exactly BOOT_WAIT cycles after cam_reset is released.
    // BOOT_WAIT must therefore be at least 3.
    localparam logic [CNT_W-1:0] T_BOOT_END = CNT_W'(BOOT_WAIT - 3);
    localparam logic [CNT_W-1:0] T_C        = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] T_2C       = CNT_W'(2*CLK_DIV);
    localparam logic [CNT_W-1:0] T_3C       = CNT_W'(3*CLK_DIV);
    localparam logic [CNT_W-1:0] T_3C_END   = CNT_W'(3*CLK_DIV - 1);
    localparam logic [CNT_W-1:0] T_BIT_END  = CNT_W'(4*CLK_DIV - 1);
    localparam logic [XW-1:0]    X_END      = XW'(XCLK_DIV - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        bit_idx, bit_n;
    logic [1:0]        byte_idx, byte_n;
    logic [15:0]       data_q, data_n;
    logic [ROM_AW-1:0] addr_n;
    logic              accept;
    logic              nack_set;
    logic              reset_release;
    logic [7:0]        tx_byte_n;
    logic              scl_n;
    logic              sda_oe_n;
    logic [XW-1:0]     xcnt;

    assign dbg_state = state;

    // Camera clock divider, independent of the sequencer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xcnt     <= '0;
            cam_xclk <= 1'b0;
        end else if (xcnt == X_END) begin
            xcnt     <= '0;
            cam_xclk <= ~cam_xclk;
        end else begin
            xcnt <= xcnt + XW'(1);
        end
    end

    // Next-state logic: sequencing of power-up, ROM fetch and SCCB bit timing.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt + T_ONE;
        bit_n         = bit_idx;
        byte_n        = byte_idx;
        data_n        = data_q;
        addr_n        = rom_addr;
        accept        = 1'b0;
        nack_set      = 1'b0;
        reset_release = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                cnt_n   = '0;
                state_n = S_IDLE;
                if (start) begin
                    accept  = 1'b1;
                    addr_n  = '0;
                    state_n = S_PWRUP;
                end
            end
            S_PWRUP: begin
                if (cnt == T_RST_END) begin
                    reset_release = 1'b1;
                    cnt_n         = '0;
                    state_n       = S_BOOT;
                end
            end
            S_BOOT: begin
                if (cnt == T_BOOT_END) begin
                    cnt_n   = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                // Cycle 0 waits out the ROM latency; cycle 1 sees valid data.
                if (cnt == T_ONE) begin
                    cnt_n   = '0;
                    data_n  = rom_data;
                    state_n = (rom_data == 16'hFFFF) ? S_FIN : S_START;
                end
            end
            S_START: begin
                if (cnt == T_3C_END) begin
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    byte_n  = 2'd0;
                    state_n = S_BYTE;
                end
            end
            S_BYTE: begin
                if (cnt == T_BIT_END) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = S_ACK;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (cnt == T_2C && sda_in) begin
                    nack_set = 1'b1;
                end
                if (cnt == T_BIT_END) begin
                    cnt_n = '0;
                    if (byte_idx == 2'd2) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n   = 3'd0;
                        byte_n  = byte_idx + 2'd1;
                        state_n = S_BYTE;
                    end
                end
            end
            S_STOP: begin
                if (cnt == T_3C_END) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == T_BIT_END) begin
                    cnt_n = '0;
                    if (&rom_addr) begin
                        state_n = S_FIN;
                    end else begin
                        addr_n  = rom_addr + ROM_AW'(1);
                        state_n = S_FETCH;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Bus pin values for the next cycle, derived from the next state so the
    // pins come straight from flops.
    always_comb begin
        tx_byte_n = SLAVE_ADDR;
        case (byte_n)
            2'd1:    tx_byte_n = data_n[15:8];
            2'd2:    tx_byte_n = data_n[7:0];
            default: tx_byte_n = SLAVE_ADDR;
        endcase
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
        case (state_n)
            S_START: begin
                scl_n    = (cnt_n < T_2C);
                sda_oe_n = 1'b1;
            end
            S_BYTE: begin
                scl_n    = (cnt_n >= T_C) && (cnt_n < T_3C);
                sda_oe_n = ~tx_byte_n[3'd7 - bit_n];
            end
            S_ACK: begin
                scl_n    = (cnt_n >= T_C) && (cnt_n < T_3C);
                sda_oe_n = 1'b0;
            end
            S_STOP: begin
                scl_n    = (cnt_n >= T_C);
                sda_oe_n = 1'b1;
            end
            default: begin
                scl_n    = 1'b1;
                sda_oe_n = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset releases the bus and
    // powers the camera down immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            data_q    <= 16'h0000;
            rom_addr  <= '0;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack_err  <= 1'b0;
            cam_pwdn  <= 1'b1;
            cam_reset <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            data_q   <= data_n;
            rom_addr <= addr_n;
            scl      <= scl_n;
            sda_oe   <= sda_oe_n;
            busy     <= (state_n != S_IDLE) && (state_n != S_FIN);
            if (accept) begin
                done <= 1'b0;
            end else if (state_n == S_FIN) begin
                done <= 1'b1;
            end
            if (accept) begin
                nack_err <= 1'b0;
            end else if (nack_set) begin
                nack_err <= 1'b1;
            end
            if (accept) begin
                cam_pwdn <= 1'b0;
            end
            if (accept) begin
                cam_reset <= 1'b0;
            end else if (reset_release) begin
                cam_reset <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_sccb_init.sv
// Bench for cam_sccb_init: a bus decoder reconstructs SCCB transactions from
// the pins and checks them against the byte stream implied by the ROM table,
// alongside power-up timing, bit timing and the flag outputs.
module tb_cam_sccb_init;

  localparam int CLK_DIV    = 2;
  localparam int XCLK_DIV   = 2;
  localparam int RESET_HOLD = 8;
  localparam int BOOT_WAIT  = 16;
  localparam int W          = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT 1 (main) ----------------
  logic        start = 1'b0;
  logic        busy, done, nack_err, cam_xclk, cam_pwdn, cam_reset, scl, sda_oe;
  logic        sda_in = 1'b1;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  dbg_state;

  cam_sccb_init #(
    .CLK_DIV(CLK_DIV), .XCLK_DIV(XCLK_DIV), .SLAVE_ADDR(8'h42),
    .RESET_HOLD(RESET_HOLD), .BOOT_WAIT(BOOT_WAIT), .ROM_AW(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .nack_err(nack_err), .cam_xclk(cam_xclk), .cam_pwdn(cam_pwdn),
    .cam_reset(cam_reset), .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
  );

  // ---------------- DUT 2 (4-entry address space, no terminator) ----------------
  logic        start2 = 1'b0;
  logic        busy2, done2, nack2, xclk2, pwdn2, reset2, scl2, sda2;
  logic        sda_in2 = 1'b0;
  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2 = 16'h1234;
  logic [3:0]  dbg_state2;

  cam_sccb_init #(
    .CLK_DIV(CLK_DIV), .XCLK_DIV(XCLK_DIV), .SLAVE_ADDR(8'h42),
    .RESET_HOLD(RESET_HOLD), .BOOT_WAIT(BOOT_WAIT), .ROM_AW(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .nack_err(nack2), .cam_xclk(xclk2), .cam_pwdn(pwdn2),
    .cam_reset(reset2), .scl(scl2), .sda_oe(sda2), .sda_in(sda_in2),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .dbg_state(dbg_state2)
  );

  // ---------------- ROM model ----------------
  logic [15:0] rom_mem [0:255];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [15:0]  tbl[$];
  int           exp_addr;
  int           exp_txn;
  int           txn_cnt;
  bit           mdl_nack;
  int           ack_mode;   // 0 = always ACK, 1 = never ACK, 2 = random per byte
  int           start_cyc;

  // monitor state
  bit         in_txn, hi_valid, boot_pending, stop_valid, xc_seen, ack_this, ack_window;
  int         bits, pos, hi_start, stop_cyc, reset_rise_cyc, xc_cnt;
  logic [7:0] cur;
  logic       p_scl, p_sda, p_xclk, p_pwdn, p_reset;
  int         starts2;
  logic       p_scl2, p_sda2;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Bus decoder and SDA slave model, evaluated every cycle away from the edge.
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 0; bits = 0; hi_valid = 0; boot_pending = 0; stop_valid = 0;
      xc_seen = 0; xc_cnt = 0; ack_this = 0; sda_in = 1'b1;
      p_scl = scl; p_sda = sda_oe; p_xclk = cam_xclk; p_pwdn = cam_pwdn; p_reset = cam_reset;
    end else begin
      xc_cnt++;
      if (cam_xclk != p_xclk) begin
        if (xc_seen) chk("xclk_half_period", xc_cnt, XCLK_DIV);
        xc_seen = 1; xc_cnt = 0;
      end
      if (p_pwdn && !cam_pwdn) chk("pwdn_fall_latency", cyc - start_cyc, 1);
      if (!p_reset && cam_reset) begin
        chk("reset_hold", cyc - start_cyc, RESET_HOLD + 1);
        reset_rise_cyc = cyc; boot_pending = 1;
      end
      if (sda_oe != p_sda) begin
        chk("sda_scl_same_edge", scl != p_scl, 0);
        if (scl && p_scl) begin
          if (sda_oe) begin
            chk("start_outside_txn", in_txn, 0);
            if (boot_pending) begin
              chk("boot_wait", cyc - reset_rise_cyc, BOOT_WAIT);
              boot_pending = 0;
            end
            if (stop_valid) chk("bus_gap_min", (cyc - stop_cyc) >= 8, 1);
            in_txn = 1; bits = 0; hi_valid = 0; cur = 8'h00;
          end else begin
            chk("stop_inside_txn", in_txn, 1);
            chk("stop_after_27_bits", bits, 27);
            in_txn = 0; txn_cnt++; stop_cyc = cyc; stop_valid = 1;
          end
        end
      end
      if (scl && !p_scl && in_txn && bits < 27) begin
        bits++; pos = (bits - 1) % 9; hi_valid = 1; hi_start = cyc;
        if (pos < 8) begin
          cur = {cur[6:0], ~sda_oe};
          if (pos == 7) begin
            obs_q.push_back(cur);
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_byte: got 0x%0h expected no further byte", cur);
            end else begin
              chk("byte", cur, exp_q.pop_front());
            end
          end
        end else begin
          chk("ack_released", sda_oe, 0);
          if (sda_in) mdl_nack = 1;
        end
      end
      if (!scl && p_scl && hi_valid) begin
        chk("scl_high_time", cyc - hi_start, 2*CLK_DIV);
        hi_valid = 0;
        if (in_txn && bits % 9 == 8)
          ack_this = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      ack_window = in_txn && (((bits % 9 == 8) && !scl) || ((bits % 9 == 0) && bits > 0 && hi_valid));
      sda_in = !(sda_oe || (ack_window && ack_this));
      p_scl = scl; p_sda = sda_oe; p_xclk = cam_xclk; p_pwdn = cam_pwdn; p_reset = cam_reset;
    end
  end

  // START-condition counter for the second instance.
  always @(negedge clk) begin
    if (rst) begin
      starts2 = 0;
    end else if (scl2 && p_scl2 && sda2 && !p_sda2) begin
      starts2++;
    end
    p_scl2 = scl2; p_sda2 = sda2;
  end

  // ---------------- driver tasks ----------------
  task automatic prepare();
    bit found;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
    foreach (tbl[i]) rom_mem[i] = tbl[i];
    exp_q.delete(); obs_q.delete();
    exp_txn = 0; exp_addr = 255; found = 0;
    for (int i = 0; i < 256; i++) begin
      if (!found) begin
        if (rom_mem[i] == 16'hFFFF) begin
          found = 1; exp_addr = i;
        end else begin
          exp_q.push_back(8'h42);
          exp_q.push_back(rom_mem[i][15:8]);
          exp_q.push_back(rom_mem[i][7:0]);
          exp_txn++;
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; start_cyc = cyc; mdl_nack = 0; txn_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("nack_cleared", nack_err, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_within_budget", done, 1);
  endtask

  task automatic finish_checks();
    chk("end_busy", busy, 0);
    chk("end_nack", nack_err, mdl_nack);
    chk("end_rom_addr", rom_addr, exp_addr);
    chk("end_bytes_left", exp_q.size(), 0);
    chk("end_txn_count", txn_cnt, exp_txn);
    chk("end_scl_idle", scl, 1);
    chk("end_sda_idle", sda_oe, 0);
  endtask

  task automatic run_table(input bit spurious);
    prepare();
    do_start();
    if (spurious) begin
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (in_txn && bits >= 5) break;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignores_start", busy, 1);
    end
    wait_done(4000);
    finish_checks();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_pwdn", cam_pwdn, 1);
    chk("rst_cam_reset", cam_reset, 0);
    chk("rst_xclk", cam_xclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack_err, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single entry, every byte acknowledged
    ack_mode = 0;
    tbl = '{16'h1280, 16'hFFFF};
    run_table(0);
    chk("t1_nbytes", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("t1_byte0", obs_q[0], 8'h42);
      chk("t1_byte1", obs_q[1], 8'h12);
      chk("t1_byte2", obs_q[2], 8'h80);
    end
    chk("t1_done", done, 1);
    chk("t1_nack", nack_err, 0);
    chk("t1_rom_addr", rom_addr, 1);

    // slave never acknowledges
    ack_mode = 1;
    run_table(0);
    chk("t2_nack", nack_err, 1);
    chk("t2_txn", txn_cnt, 1);

    // three entries in order, with a start pulse while busy
    ack_mode = 0;
    tbl = '{16'h1101, 16'h3A04, 16'h40D0, 16'hFFFF};
    run_table(1);
    chk("t3_nack", nack_err, 0);
    chk("t3_rom_addr", rom_addr, 3);

    // random tables and random acknowledge pattern
    ack_mode = 2;
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(1, 3);
      tbl.delete();
      for (int k = 0; k < n; k++) tbl.push_back(16'($urandom_range(0, 16'hFFFE)));
      tbl.push_back(16'hFFFF);
      run_table(0);
    end

    // reset in the middle of the second byte, then a full replay
    ack_mode = 0;
    tbl = '{16'h1101, 16'h3A04, 16'h40D0, 16'hFFFF};
    prepare();
    do_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_txn && bits >= 12) break;
    end
    chk("mid_reach_byte2", in_txn && bits >= 12, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_pwdn", cam_pwdn, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cam_reset", cam_reset, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_table(0);
    chk("mid_replay_rom_addr", rom_addr, 3);

    // second instance: address space exhausted without a terminator
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done2) break;
    end
    chk("aw2_done", done2, 1);
    chk("aw2_busy", busy2, 0);
    chk("aw2_rom_addr", rom_addr2, 3);
    chk("aw2_transactions", starts2, 4);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- global watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cam_sccb_init.md
Name: cam_sccb_init

Overview:
Camera bring-up sequencer that sits directly upstream of the camera GPIO pins on the iCE40 camera board. It generates XCLK and drives PWDN/RESET through the power-up sequence. It then streams a register table from an external synchronous ROM over SCCB: a write-only, I2C-like bus with a push-pull SCL and an open-drain SDA. It runs off the internal HFOSC-derived clock and reports completion and ACK errors to the top level.

Parameters:
CLK_DIV, 12, clk cycles per SCL quarter-bit; one bit period is 4*CLK_DIV cycles.
XCLK_DIV, 2, cam_xclk toggles every XCLK_DIV clk cycles; must be at least 1.
SLAVE_ADDR, 8'h42, SCCB write address sent as the first byte.
RESET_HOLD, 48000, clk cycles with cam_reset low after start.
BOOT_WAIT, 48000, clk cycles to wait after cam_reset is released, before the first transaction.
ROM_AW, 8, rom_addr width; also the maximum table length of 2^ROM_AW entries.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins the sequence
busy  out  1  high from the cycle after an accepted start until done
done  out  1  sticky; set at end of table, cleared by the next accepted start
nack_err  out  1  sticky; set when any ACK bit is sampled high
cam_xclk  out  1  free-running camera clock
cam_pwdn  out  1  camera power-down, active high
cam_reset  out  1  camera reset, active low
scl  out  1  SCCB clock, push-pull
sda_oe  out  1  1 = pull SDA low; 0 = release SDA (pulled high externally)
sda_in  in  1  SDA pad input
rom_addr  out  ROM_AW  table index
rom_data  in  16  {reg_addr[15:8], value[7:0]}, valid 1 clk after rom_addr changes

Behaviour:
- Reset values: scl=1, sda_oe=0, cam_pwdn=1, cam_reset=0, cam_xclk=0, busy=0, done=0, nack_err=0, rom_addr=0, FSM=IDLE.
- cam_xclk runs continuously whenever rst is low, regardless of FSM state.
- FSM states: IDLE, PWRUP, BOOT, FETCH, START, BYTE, ACK, STOP, GAP, FIN.
- IDLE:
  - On start: go to PWRUP; busy=1; done=0; nack_err=0; rom_addr=0.
  - start while busy is ignored.
- PWRUP:
  - Cycle 1: cam_pwdn=0, cam_reset=0.
  - cam_reset is held low for RESET_HOLD cycles, then cam_reset=1 and go to BOOT.
- BOOT: wait BOOT_WAIT cycles, then go to FETCH.
- FETCH: wait 1 cycle for ROM latency, then latch rom_data.
  - If rom_data == 16'hFFFF, go to FIN.
  - Otherwise go to START.
- START:
  - SDA is pulled low while SCL is high; hold 2*CLK_DIV cycles.
  - Then scl=0; hold CLK_DIV cycles.
- BYTE: sends bytes in order SLAVE_ADDR, reg_addr, value, MSB first.
  - Per bit: set sda_oe=~bit while scl=0.
  - scl rises after CLK_DIV cycles, stays high 2*CLK_DIV cycles, then falls for CLK_DIV cycles.
  - SDA changes only while scl is low.
- ACK (9th bit):
  - sda_oe=0; sda_in is sampled at the midpoint of scl high.
  - If sda_in=1, set nack_err. The transaction continues regardless.
  - After the 3rd byte's ACK, go to STOP.
- STOP:
  - scl=0 with sda_oe=1; then scl=1; after 2*CLK_DIV cycles, sda_oe=0.
- GAP:
  - Bus idle (scl=1, sda_oe=0) for 4*CLK_DIV cycles.
  - Then rom_addr increments and the FSM goes to FETCH.
  - If rom_addr is already all-ones, go to FIN instead; rom_addr does not wrap.
- FIN: busy=0, done=1, back to IDLE.
  - A later start re-runs the full sequence, including PWRUP.
- Transaction length: 3 bytes × 9 bits × 4*CLK_DIV = 108*CLK_DIV cycles, plus start, stop and gap overhead.
- Reset mid-operation:
  - All outputs return to reset values immediately, asynchronously.
  - The bus is released (scl=1, sda_oe=0) and the camera is put back into PWDN.
  - No STOP condition is emitted; the next power-up resets the camera anyway.
- Simultaneous start and rst: rst wins.

Test Plan:
- Params CLK_DIV=2, RESET_HOLD=8, BOOT_WAIT=16; ROM = {16'h1280, 16'hFFFF}; SDA model ACKs every byte.
  - Expect cam_pwdn falls 1 cycle after start; cam_reset rises 8 cycles later; first SDA fall 16 cycles after that.
  - Decoded bytes are 0x42, 0x12, 0x80; done=1; nack_err=0; rom_addr=1.
- SDA model never ACKs (sda_in=1 throughout): all 3 bytes are still sent, STOP is issued, done=1, nack_err=1.
- Three-entry table {16'h1101, 16'h3A04, 16'h40D0} then 16'hFFFF:
  - Three complete transactions in table order.
  - Idle gap of at least 8 cycles between each STOP and the following START.
- Bus protocol checker over the entire run:
  - SDA changes only while scl=0, except at START and STOP.
  - scl high time = 4 cycles; cam_xclk period = 4 cycles throughout.
- Assert rst midway through the second byte:
  - Same cycle: scl=1, sda_oe=0, cam_pwdn=1, busy=0.
  - A new start then completes the full table.
- Second start while busy is ignored (transaction trace unchanged).
- Start after done clears done and nack_err and replays from rom_addr=0.
